// File: rtl/keyword_lexer.sv
// Lexing front end for the begin/end nesting checker: folds case, splits words on
// non-letters, classifies each word as BEGIN/END/OTHER and queues tokens in a small FIFO.
module keyword_lexer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    input  logic             flush,
    output logic             in_ready,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [1:0]       tok_kind,
    output logic [LEN_W-1:0] tok_len,
    output logic [15:0]      tok_count,
    output logic             len_sat
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_B1   = 4'd1,
        S_B2   = 4'd2,
        S_B3   = 4'd3,
        S_B4   = 4'd4,
        S_B5   = 4'd5,
        S_E1   = 4'd6,
        S_E2   = 4'd7,
        S_E3   = 4'd8,
        S_WORD = 4'd9
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_len_sat;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [1:0]       r_kind_mem [FIFO_DEPTH];
    logic [LEN_W-1:0] r_len_mem  [FIFO_DEPTH];
    logic [15:0]      r_tok_count;
    logic             r_in_ready;

    logic             w_is_upper;
    logic             w_is_lower;
    logic             w_letter_acc;
    logic             w_sep_acc;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [7:0]       w_lc;
    logic [PW-1:0]    w_occ;
    logic [PW-1:0]    w_occ_next;

    // Advance the keyword prefix matcher by one lowercase letter.
    function automatic state_t next_prefix(input state_t s, input logic [7:0] c);
        state_t n;
        n = S_WORD;
        case (s)
            S_IDLE:  n = (c == 8'h62) ? S_B1 : ((c == 8'h65) ? S_E1 : S_WORD);
            S_B1:    n = (c == 8'h65) ? S_B2 : S_WORD;
            S_B2:    n = (c == 8'h67) ? S_B3 : S_WORD;
            S_B3:    n = (c == 8'h69) ? S_B4 : S_WORD;
            S_B4:    n = (c == 8'h6E) ? S_B5 : S_WORD;
            S_E1:    n = (c == 8'h6E) ? S_E2 : S_WORD;
            S_E2:    n = (c == 8'h64) ? S_E3 : S_WORD;
            default: n = S_WORD;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] token_kind(input state_t s);
        logic [1:0] k;
        case (s)
            S_B5:    k = 2'b01;
            S_E3:    k = 2'b10;
            default: k = 2'b11;
        endcase
        return k;
    endfunction

    // Character decode, accept strobes and FIFO occupancy bookkeeping.
    always_comb begin
        w_is_upper   = (in_char >= 8'h41) && (in_char <= 8'h5A);
        w_is_lower   = (in_char >= 8'h61) && (in_char <= 8'h7A);
        if (w_is_upper) begin
            w_lc = in_char | 8'h20;
        end else begin
            w_lc = in_char;
        end
        w_letter_acc = in_valid & r_in_ready & (w_is_upper | w_is_lower);
        // A flush only counts in cycles with no character, and then acts as a separator.
        w_sep_acc    = (in_valid & r_in_ready & ~(w_is_upper | w_is_lower))
                     | (flush & ~in_valid & r_in_ready);
        w_push       = w_sep_acc & (r_state != S_IDLE);
        w_occ        = r_wr_ptr - r_rd_ptr;
        w_empty      = (w_occ == {PW{1'b0}});
        w_pop        = ~w_empty & tok_ready;
        w_occ_next   = w_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end

    // Word matcher and saturating length counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_len     <= {LEN_W{1'b0}};
            r_len_sat <= 1'b0;
        end else if (w_letter_acc) begin
            r_state <= next_prefix(r_state, w_lc);
            if (r_state == S_IDLE) begin
                r_len <= {{(LEN_W-1){1'b0}}, 1'b1};
            end else if (r_len != LEN_MAX) begin
                r_len <= r_len + {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                r_len_sat <= 1'b1;
            end
        end else if (w_sep_acc) begin
            r_state <= S_IDLE;
            r_len   <= {LEN_W{1'b0}};
        end else begin
            r_state <= r_state;
            r_len   <= r_len;
        end
    end

    // Token FIFO, push counter and registered input-ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_tok_count <= 16'd0;
            r_in_ready  <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_kind_mem[i] <= 2'b00;
                r_len_mem[i]  <= {LEN_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_kind_mem[r_wr_ptr[AW-1:0]] <= token_kind(r_state);
                r_len_mem[r_wr_ptr[AW-1:0]]  <= r_len;
                r_wr_ptr    <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
                r_tok_count <= r_tok_count + 16'd1;
            end else begin
                r_wr_ptr    <= r_wr_ptr;
                r_tok_count <= r_tok_count;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_in_ready <= (w_occ_next != DEPTH_P);
        end
    end

    assign in_ready  = r_in_ready;
    assign tok_valid = ~w_empty;
    assign tok_kind  = w_empty ? 2'b00 : r_kind_mem[r_rd_ptr[AW-1:0]];
    assign tok_len   = w_empty ? {LEN_W{1'b0}} : r_len_mem[r_rd_ptr[AW-1:0]];
    assign tok_count = r_tok_count;
    assign len_sat   = r_len_sat;

endmodule

// File: tb/tb_keyword_lexer.sv
// Directed bench for keyword_lexer: streams text, captures popped tokens and
// compares them with hand-derived (kind, length) pairs.
module tb_keyword_lexer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_char;
    logic       flush;
    logic       in_ready;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_kind;
    logic [7:0] tok_len;
    logic [15:0] tok_count;
    logic       len_sat;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] cap_q [$];

    keyword_lexer #(.FIFO_DEPTH(4), .LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .flush     (flush),
        .in_ready  (in_ready),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_kind  (tok_kind),
        .tok_len   (tok_len),
        .tok_count (tok_count),
        .len_sat   (len_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every token the downstream side takes.
    always @(posedge clk) begin
        if (reset && tok_valid && tok_ready) begin
            cap_q.push_back({tok_kind, tok_len});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input byte c);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = c;
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic send_flush();
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic expect_tok(input string tag, input logic [1:0] k, input logic [7:0] l);
        logic [9:0] got;
        got = 10'h000;
        if (cap_q.size() > 0) got = cap_q.pop_front();
        check(tag, {22'd0, got}, {22'd0, k, l});
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        flush     = 1'b0;
        tok_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_tok_valid", 32'(tok_valid), 32'd0);
        check("rst_tok_kind", 32'(tok_kind), 32'd0);
        check("rst_tok_len", 32'(tok_len), 32'd0);
        check("rst_tok_count", 32'(tok_count), 32'd0);
        check("rst_len_sat", 32'(len_sat), 32'd0);
        reset = 1'b1;

        // Basic stream
        send_str("Begin");
        check("basic_pre_vld", 32'(tok_valid), 32'd0);
        send_char(" ");
        check("basic_vld", 32'(tok_valid), 32'd1);
        check("basic_kind0", 32'(tok_kind), 32'd1);
        check("basic_len0", 32'(tok_len), 32'd5);
        send_str("end ");
        check("basic_vld1", 32'(tok_valid), 32'd1);
        send_str("x ");
        repeat (3) @(negedge clk);
        expect_tok("basic_t0", 2'b01, 8'd5);
        expect_tok("basic_t1", 2'b10, 8'd3);
        expect_tok("basic_t2", 2'b11, 8'd1);
        check("basic_extra", 32'(cap_q.size()), 32'd0);
        check("basic_count", 32'(tok_count), 32'd3);

        // Near-miss words
        send_str("BEG ENDS begins ");
        repeat (3) @(negedge clk);
        expect_tok("near_t0", 2'b11, 8'd3);
        expect_tok("near_t1", 2'b11, 8'd4);
        expect_tok("near_t2", 2'b11, 8'd6);
        check("near_extra", 32'(cap_q.size()), 32'd0);
        check("near_count", 32'(tok_count), 32'd6);

        // Flush terminates a word; separator runs produce nothing
        send_str("end");
        send_flush();
        check("flush_vld", 32'(tok_valid), 32'd1);
        check("flush_kind", 32'(tok_kind), 32'd2);
        repeat (3) @(negedge clk);
        expect_tok("flush_t0", 2'b10, 8'd3);
        send_str("     ");
        send_flush();
        repeat (3) @(negedge clk);
        check("sep_none", 32'(cap_q.size()), 32'd0);
        check("sep_vld", 32'(tok_valid), 32'd0);
        check("sep_count", 32'(tok_count), 32'd7);

        // Backpressure with mixed tokens: head held, order kept
        tok_ready = 1'b0;
        send_str("ab begin c end ");
        check("hold_full", 32'(in_ready), 32'd0);
        check("hold_kind_a", 32'(tok_kind), 32'd3);
        check("hold_len_a", 32'(tok_len), 32'd2);
        repeat (3) @(negedge clk);
        check("hold_len_b", 32'(tok_len), 32'd2);
        check("hold_vld", 32'(tok_valid), 32'd1);
        tok_ready = 1'b1;
        repeat (8) @(negedge clk);
        expect_tok("mix_t0", 2'b11, 8'd2);
        expect_tok("mix_t1", 2'b01, 8'd5);
        expect_tok("mix_t2", 2'b11, 8'd1);
        expect_tok("mix_t3", 2'b10, 8'd3);
        check("mix_extra", 32'(cap_q.size()), 32'd0);

        // Backpressure: 'e' stalls until a pop frees a slot
        tok_ready = 1'b0;
        send_str("a b c d ");
        check("bp_full", 32'(in_ready), 32'd0);
        fork
            send_str("e ");
            begin
                repeat (5) @(negedge clk);
                check("bp_stall_rdy", 32'(in_ready), 32'd0);
                check("bp_stall_cnt", 32'(tok_count), 32'd15);
                tok_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        check("bp_drained", 32'(cap_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) expect_tok("bp_tok", 2'b11, 8'd1);
        check("bp_empty", 32'(tok_valid), 32'd0);
        check("bp_count", 32'(tok_count), 32'd16);
        check("bp_rdy", 32'(in_ready), 32'd1);

        // Length saturation
        check("sat_pre", 32'(len_sat), 32'd0);
        for (int i = 0; i < 300; i++) send_char("z");
        send_char(" ");
        repeat (3) @(negedge clk);
        expect_tok("sat_tok", 2'b11, 8'd255);
        check("sat_flag", 32'(len_sat), 32'd1);
        send_str("q ");
        repeat (3) @(negedge clk);
        expect_tok("sat_after", 2'b11, 8'd1);
        check("sat_sticky", 32'(len_sat), 32'd1);
        check("sat_count", 32'(tok_count), 32'd18);

        // Asynchronous reset mid-word with tokens queued
        tok_ready = 1'b0;
        send_str("a bb beg");
        check("ar_pre_vld", 32'(tok_valid), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_tok_valid", 32'(tok_valid), 32'd0);
        check("ar_tok_kind", 32'(tok_kind), 32'd0);
        check("ar_tok_len", 32'(tok_len), 32'd0);
        check("ar_tok_count", 32'(tok_count), 32'd0);
        check("ar_len_sat", 32'(len_sat), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cap_q.delete();
        tok_ready = 1'b1;
        send_str("end ");
        repeat (3) @(negedge clk);
        expect_tok("ar_tok", 2'b10, 8'd3);
        check("ar_extra", 32'(cap_q.size()), 32'd0);
        check("ar_count", 32'(tok_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keyword_lexer.md
# keyword_lexer

Upstream lexing stage for the begin/end nesting checker. Consumes a handshaked character stream, case-folds letters, splits words on any non-letter, and classifies each completed word as BEGIN, END or OTHER. Completed tokens, with their word length, are buffered in a small FIFO and presented downstream on a valid/ready interface.

## Interface
- `FIFO_DEPTH`, default 4: token FIFO entries; power of two, at least 2.
- `LEN_W`, default 8: width of the word-length field.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_char` is valid this cycle.
- `in_char`  in  8: ASCII character.
- `flush`  in  1: end-of-stream marker; terminates any pending word.
- `in_ready`  out  1: lexer accepts a character or flush this cycle.
- `tok_valid`  out  1: FIFO head holds a token.
- `tok_ready`  in  1: downstream accepts the head token.
- `tok_kind`  out  2: 2'b01 BEGIN, 2'b10 END, 2'b11 OTHER; 2'b00 only when the FIFO is empty.
- `tok_len`  out  LEN_W: letter count of the token, saturating.
- `tok_count`  out  16: tokens pushed since reset; wraps modulo 2^16.
- `len_sat`  out  1: sticky; set when any word length saturated.

## Operation
- **Character accept.** A character is accepted when `in_valid & in_ready`.
- **Flush accept.** A flush is accepted when `flush & ~in_valid & in_ready`.
  - `flush` is ignored in any cycle where `in_valid` is high.
- **`in_ready`.** Equals `~fifo_full`, registered. It does not depend on `tok_ready` in the same cycle: a full FIFO refuses input even while it is being popped.
- **Classification.**
  - Letters a-z and A-Z are letters; uppercase is folded to lowercase.
  - Every other byte is a separator.
  - An accepted flush behaves as a separator.
- **Matcher states:** IDLE, B1, B2, B3, B4, B5, E1, E2, E3, WORD.
  - B1..B5 mean the prefix "b", "be", "beg", "begi", "begin" has been matched.
  - E1..E3 mean "e", "en", "end" has been matched.
  - WORD means any other letter sequence.
- **Transitions on an accepted letter.**
  - IDLE: 'b' goes to B1, 'e' goes to E1, any other letter goes to WORD.
  - Bk/Ek: go to the next prefix state if the letter matches the next expected letter, otherwise to WORD.
  - B5, E3 and WORD: any letter goes to WORD.
- **Word length.** The counter loads 1 on the first letter and increments on each further letter, saturating at 2^LEN_W-1. Saturation sets `len_sat`.
- **Accepted separator in a non-IDLE state.**
  - Push one token: kind BEGIN if in B5, END if in E3, otherwise OTHER (so "beg" and "ends" are OTHER).
  - Push the current length and increment `tok_count`.
  - Return to IDLE.
- **Accepted separator in IDLE.** No push; consecutive separators produce nothing.
- **Pop.** `tok_valid & tok_ready` removes the head entry. A push and a pop in the same cycle are both performed and the occupancy is unchanged.
- **Output hold.** `tok_kind` and `tok_len` are stable while `tok_valid` is high and `tok_ready` is low.
- **Reset mid-word.** The pending word is discarded, the FIFO is emptied, and no partial token is ever emitted.

## Timing
- **Reset values:**
  - `in_ready`=1
  - `tok_valid`=0
  - `tok_kind`=0
  - `tok_len`=0
  - `tok_count`=0
  - `len_sat`=0
  - matcher in IDLE, length counter 0, FIFO pointers 0.
- **Push-to-output latency.** A separator accepted at edge N makes the token visible, with `tok_valid`=1, after edge N; it can be popped at edge N+1 at the earliest.
- **Pop-to-output latency.** After a pop at edge N, the next entry (or `tok_valid`=0 with `tok_kind`=0) is visible after edge N.
- **`in_ready` update.** Falls the cycle after the push that fills the FIFO. Rises the cycle after the pop that leaves a free slot.
- **Throughput.** One character per cycle while not full; at most one token pushed per cycle.
- **Counters.** `tok_count` updates on the same edge as the push. The FIFO uses wrap-around pointers with an extra bit to distinguish full from empty.

## Test plan
- **Basic stream.** Stream "Begin end x " with `tok_ready`=1. Require tokens (01,5), (10,3), (11,1) in order and `tok_count`=3. Each `tok_valid` rises the cycle after its space is accepted.
- **Near-miss words.** Stream "BEG ENDS begins ". Require three tokens of kind 11 with lengths 3, 4, 6, and none of kind 01 or 10.
- **Flush and separator runs.** Stream "end" then a cycle of `flush`=1 with `in_valid`=0. Require one token (10,3). Then send 5 spaces plus a flush and require no further tokens.
- **Backpressure.** With `FIFO_DEPTH`=4 and `tok_ready`=0, stream "a b c d e ".
  - `in_ready` falls the cycle after the 4th token push; the 'e' stalls with no loss.
  - Raise `tok_ready`: tokens are drained in order a, b, c, d, e; a push and pop in the same cycle keeps the count correct.
- **Length saturation.** Stream 300 letters 'z' then a space, with `LEN_W`=8. Require `tok_len`=255, kind 11, and `len_sat`=1, held until reset.
- **Async reset.** Assert `reset` low mid-word ("beg") with 2 tokens queued. Outputs return to reset values immediately, without waiting for `clk`. After release, stream "end " and require a single token (10,3) with `tok_count`=1.
